// File: rtl/trigger_capture.sv
// Level-crossing trigger with decimated capture into a ping-pong trace buffer; banks swap on frame_done in HOLD.
// screenData has 1-cycle read latency. Define TRIG_AUTO_EN to add the forced trigger after AUTO_TIMEOUT samples.
module trigger_capture #(
   parameter int DW           = 12,
   parameter int DEPTH        = 640,
   parameter int AW           = 10,
   parameter int AUTO_TIMEOUT = 65535
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          sample_valid,
   input  logic [DW-1:0] data,
   input  logic [3:0]    decim,
   input  logic [DW-1:0] trig_level,
   input  logic          trig_slope,
   input  logic          arm,
   input  logic          frame_done,
   input  logic [10:0]   screenX,
   output logic [DW-1:0] screenData,
   output logic          triggered,
   output logic          busy,
   output logic          resample
);

   typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, HOLD} state_t;

   state_t        state_q;
   logic [3:0]    dcnt_q, dcnt_d;
   logic [DW-1:0] prev_q;
   logic          prev_valid_q;
   logic [AW-1:0] wr_addr_q;
   logic          disp_bank_q;
   logic          triggered_q, busy_q, resample_q;
   logic [DW-1:0] rd_q;
   logic          rd_zero_q;

   logic [DW-1:0] mem [2**(AW+1)];

   logic          accept, hit, fire, we;
   logic [AW-1:0] waddr;

   // A counter that overshot a freshly lowered decim accepts on its next strobe.
   assign accept = sample_valid && (dcnt_q >= decim);

   always_comb begin
      dcnt_d = dcnt_q;
      if (sample_valid)
         dcnt_d = accept ? 4'd0 : dcnt_q + 4'd1;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) dcnt_q <= 4'd0;
      else       dcnt_q <= dcnt_d;
   end

   assign hit = prev_valid_q && (trig_slope ? (prev_q > trig_level && data <= trig_level)
                                            : (prev_q < trig_level && data >= trig_level));

`ifdef TRIG_AUTO_EN
   localparam int TW = $clog2(AUTO_TIMEOUT + 1);
   logic [TW-1:0] auto_q;
   assign fire = hit || (auto_q == TW'(AUTO_TIMEOUT));
`else
   assign fire = hit;
`endif

   assign we    = accept && ((state_q == ARMED && arm && fire) || state_q == CAPTURE);
   assign waddr = (state_q == ARMED) ? '0 : wr_addr_q;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         prev_q       <= '0;
         prev_valid_q <= 1'b0;
         wr_addr_q    <= '0;
         disp_bank_q  <= 1'b0;
         triggered_q  <= 1'b0;
         busy_q       <= 1'b0;
         resample_q   <= 1'b0;
`ifdef TRIG_AUTO_EN
         auto_q       <= '0;
`endif
      end else begin
         resample_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (arm) begin
                  state_q      <= ARMED;
                  prev_valid_q <= 1'b0;
`ifdef TRIG_AUTO_EN
                  auto_q       <= '0;
`endif
               end
            end
            ARMED: begin
               if (!arm) begin
                  state_q <= IDLE;
               end else if (accept) begin
                  prev_q       <= data;
                  prev_valid_q <= 1'b1;
                  if (fire) begin
                     wr_addr_q   <= AW'(1);
                     triggered_q <= 1'b1;
                     busy_q      <= 1'b1;
                     state_q     <= CAPTURE;
                  end
`ifdef TRIG_AUTO_EN
                  else begin
                     auto_q <= auto_q + TW'(1);
                  end
`endif
               end
            end
            CAPTURE: begin
               if (accept) begin
                  wr_addr_q <= wr_addr_q + AW'(1);
                  if (wr_addr_q == AW'(DEPTH - 1)) begin
                     busy_q  <= 1'b0;
                     state_q <= HOLD;
                  end
               end
            end
            HOLD: begin
               if (frame_done) begin
                  disp_bank_q <= ~disp_bank_q;
                  resample_q  <= 1'b1;
                  triggered_q <= 1'b0;
                  if (arm) begin
                     state_q      <= ARMED;
                     prev_valid_q <= 1'b0;
`ifdef TRIG_AUTO_EN
                     auto_q       <= '0;
`endif
                  end else begin
                     state_q <= IDLE;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Writes only ever go to the non-displayed bank, so the shown trace is never torn.
   always_ff @(posedge clock) begin
      if (we)
         mem[{~disp_bank_q, waddr}] <= data;
   end

   always_ff @(posedge clock) begin
      rd_q <= mem[{disp_bank_q, screenX[AW-1:0]}];
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) rd_zero_q <= 1'b1;
      else       rd_zero_q <= (screenX >= 11'(DEPTH));
   end

   assign screenData = rd_zero_q ? '0 : rd_q;
   assign triggered  = triggered_q;
   assign busy       = busy_q;
   assign resample   = resample_q;

endmodule

// File: tb/tb_trigger_capture.sv
// Bench for trigger_capture: vector table for trigger rules, scripted corner cases, random traces against a sample-queue model.
module tb_trigger_capture;

   localparam int DW    = 12;
   localparam int DEPTH = 640;
   localparam int AW    = 10;
   localparam int AT    = 16;

   logic          clock = 1'b0;
   logic          reset;
   logic          sample_valid;
   logic [DW-1:0] data;
   logic [3:0]    decim;
   logic [DW-1:0] trig_level;
   logic          trig_slope;
   logic          arm;
   logic          frame_done;
   logic [10:0]   screenX;
   logic [DW-1:0] screenData;
   logic          triggered, busy, resample;

   always #5 clock = ~clock;

   trigger_capture #(.DW(DW), .DEPTH(DEPTH), .AW(AW), .AUTO_TIMEOUT(AT)) dut (
      .clock(clock), .reset(reset), .sample_valid(sample_valid), .data(data),
      .decim(decim), .trig_level(trig_level), .trig_slope(trig_slope), .arm(arm),
      .frame_done(frame_done), .screenX(screenX), .screenData(screenData),
      .triggered(triggered), .busy(busy), .resample(resample)
   );

   int n_checks = 0;
   int n_fail   = 0;
   int dcnt     = 0;
   int dec_cur  = 0;
   logic [DW-1:0] disp_trace [DEPTH];
   bit disp_known = 0;

   typedef struct {
      bit            slope;
      logic [DW-1:0] lvl;
      logic [DW-1:0] d0;
      logic [DW-1:0] d1;
      bit            exp_trig;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   // One strobe; the model's decimation rule decides whether it is accepted.
   task automatic strobe(input logic [DW-1:0] d, output bit acc);
      sample_valid = 1'b1;
      data         = d;
      acc          = (dcnt >= dec_cur);
      dcnt         = acc ? 0 : dcnt + 1;
      cyc();
      sample_valid = 1'b0;
   endtask

   task automatic set_decim(input int d);
      decim   = 4'(d);
      dec_cur = d;
   endtask

   function automatic bit crossing(input logic [DW-1:0] p, input logic [DW-1:0] c,
                                   input logic [DW-1:0] l, input bit s);
      return s ? (p > l && c <= l) : (p < l && c >= l);
   endfunction

   task automatic do_reset(input string name);
      #2;
      reset = 1'b1;
      #1;
      check({name, "_triggered"}, triggered, 0);
      check({name, "_busy"}, busy, 0);
      check({name, "_resample"}, resample, 0);
      check({name, "_screenData"}, screenData, 0);
      cyc();
      reset      = 1'b0;
      dcnt       = 0;
      disp_known = 0;
   endtask

   task automatic read_check(input string name, input int x, input logic [DW-1:0] exp);
      screenX = 11'(x);
      cyc();
      check(name, screenData, exp);
   endtask

   task automatic read_trace(input string name);
      int bad = 0;
      for (int i = 0; i < DEPTH; i++) begin
         screenX = 11'(i);
         cyc();
         if (screenData !== disp_trace[i]) bad++;
      end
      check(name, bad, 0);
   endtask

   // kind: 0 ramp up, 1 random walk toward the level, 2 constant, 3 ramp down.
   task automatic capture_run(input string name, input int dec, input bit slp,
                              input logic [DW-1:0] lvl, input int kind,
                              input logic [DW-1:0] start, input bit fd_mid);
      logic [DW-1:0] acc_q[$];
      logic [DW-1:0] nt [DEPTH];
      int  tidx = -1, cap_strobes = 0, res_seen = 0, tmis = 0, hold_res = 0, n = 0;
      int  dv = int'(start);
      bit  a, done = 0;
      logic [DW-1:0] d;
      set_decim(dec);
      trig_slope = slp;
      trig_level = lvl;
      arm        = 1'b1;
      cyc();
      cyc();
      while (n < 40000) begin
         case (kind)
            0: d = start + DW'(n);
            3: d = start - DW'(n);
            2: d = start;
            default: begin
               if (n > 0) dv = slp ? dv - (int'($urandom_range(0, 11)) - 3)
                                   : dv + (int'($urandom_range(0, 11)) - 3);
               if (dv < 0) dv = 0;
               if (dv > 4095) dv = 4095;
               d = DW'(dv);
            end
         endcase
         if (fd_mid && (n % 97) == 50) frame_done = 1'b1;
         if (busy === 1'b1) cap_strobes++;
         strobe(d, a);
         frame_done = 1'b0;
         if (resample !== 1'b0) res_seen++;
         if (a) begin
            acc_q.push_back(d);
            if (tidx < 0) begin
               int k = acc_q.size() - 1;
               if (k >= 1 && crossing(acc_q[k-1], d, lvl, slp)) tidx = k;
`ifdef TRIG_AUTO_EN
               if (tidx < 0 && k == AT) tidx = k;
`endif
               if (tidx >= 0) arm = 1'b0;
            end
         end
         if (triggered !== (tidx >= 0)) tmis++;
         if (tidx >= 0 && acc_q.size() == tidx + DEPTH) begin
            done = 1;
            break;
         end
         n++;
      end
      check({name, "_capture_done"}, done, 1);
      check({name, "_trig_timing"}, tmis, 0);
      check({name, "_no_early_swap"}, res_seen, 0);
      check({name, "_busy_end"}, busy, 0);
      check({name, "_trig_held"}, triggered, 1);
      // After the trigger, 639 more accepted samples each take dec+1 strobes
      // (with the trigger sample's own window this is DEPTH*(dec+1) in total).
      check({name, "_capture_strobes"}, cap_strobes, (DEPTH - 1) * (dec + 1));
      for (int i = 0; i < DEPTH; i++)
         nt[i] = (done && tidx >= 0) ? acc_q[tidx + i] : '0;
      repeat (3) begin
         cyc();
         if (resample !== 1'b0) hold_res++;
      end
      check({name, "_hold_waits"}, hold_res, 0);
      if (disp_known) read_trace({name, "_display_held"});
      frame_done = 1'b1;
      cyc();
      frame_done = 1'b0;
      check({name, "_resample_pulse"}, resample, 1);
      check({name, "_trig_cleared"}, triggered, 0);
      cyc();
      check({name, "_resample_single"}, resample, 0);
      for (int i = 0; i < DEPTH; i++) disp_trace[i] = nt[i];
      disp_known = 1;
      read_trace({name, "_trace"});
      frame_done = 1'b1;
      cyc();
      frame_done = 1'b0;
      check({name, "_no_second_swap"}, resample, 0);
      // arm was low at the swap, so a clean crossing must now be ignored.
      for (int i = 0; i < 4 * (dec + 1); i++)
         strobe((i < 2 * (dec + 1)) ? (slp ? lvl + 1'b1 : lvl - 1'b1) : lvl, a);
      check({name, "_idle_after_swap"}, triggered, 0);
   endtask

   initial begin
      vec_t vecs[9];
      bit a;
      reset = 1'b0; sample_valid = 1'b0; data = '0; decim = '0; trig_level = '0;
      trig_slope = 1'b0; arm = 1'b0; frame_done = 1'b0; screenX = '0;

      do_reset("por");

      vecs[0] = '{1'b0, 12'h800, 12'h7FF, 12'h800, 1'b1};
      vecs[1] = '{1'b0, 12'h800, 12'h800, 12'h801, 1'b0};
      vecs[2] = '{1'b0, 12'h800, 12'h7FF, 12'h7FF, 1'b0};
      vecs[3] = '{1'b1, 12'h400, 12'h500, 12'h400, 1'b1};
      vecs[4] = '{1'b1, 12'h400, 12'h400, 12'h3FF, 1'b0};
      vecs[5] = '{1'b1, 12'h400, 12'h401, 12'h400, 1'b1};
      vecs[6] = '{1'b1, 12'h400, 12'h300, 12'h200, 1'b0};
      vecs[7] = '{1'b0, 12'h800, 12'h000, 12'hFFF, 1'b1};
      vecs[8] = '{1'b0, 12'h800, 12'h900, 12'h700, 1'b0};
      foreach (vecs[i]) begin
         reset = 1'b1;
         cyc();
         reset = 1'b0;
         dcnt  = 0;
         set_decim(0);
         trig_slope = vecs[i].slope;
         trig_level = vecs[i].lvl;
         arm = 1'b1;
         cyc();
         cyc();
         strobe(vecs[i].d0, a);
         check($sformatf("vec%0d_first_no_trig", i), triggered, 0);
         strobe(vecs[i].d1, a);
         check($sformatf("vec%0d_triggered", i), triggered, vecs[i].exp_trig);
         check($sformatf("vec%0d_busy", i), busy, vecs[i].exp_trig);
         arm = 1'b0;
      end

      // Reset in the middle of a capture.
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      dcnt  = 0;
      set_decim(0);
      trig_slope = 1'b0;
      trig_level = 12'h800;
      arm = 1'b1;
      cyc();
      cyc();
      for (int i = 0; i < 100; i++) strobe(12'h7F0 + 12'(i), a);
      check("midcap_busy", busy, 1);
      do_reset("midcap_reset");

      capture_run("ramp", 0, 1'b0, 12'h800, 0, 12'h7F0, 1'b0);
      read_check("ramp_x5", 5, 12'h805);
      read_check("ramp_x639", 639, 12'hA7F);
      read_check("oor_640", 640, 12'h000);
      read_check("oor_2047", 2047, 12'h000);

      capture_run("fall", 0, 1'b1, 12'h400, 3, 12'h410, 1'b0);
      read_check("fall_x0", 0, 12'h400);

      capture_run("decim3", 3, 1'b0, 12'h800, 0, 12'h7F0, 1'b1);

      for (int r = 0; r < 4; r++) begin
         logic [DW-1:0] lv;
         bit sl;
         lv = 12'($urandom_range(12'h100, 12'hE00));
         sl = 1'($urandom_range(0, 1));
         capture_run($sformatf("rand%0d", r), int'($urandom_range(0, 5)), sl, lv, 1,
                     sl ? lv + 12'h080 : lv - 12'h080, 1'($urandom_range(0, 1)));
      end

`ifdef TRIG_AUTO_EN
      capture_run("auto", 0, 1'b0, 12'h800, 2, 12'h100, 1'b0);
      read_check("auto_x17", 17, 12'h100);
`else
      set_decim(0);
      trig_slope = 1'b0;
      trig_level = 12'h800;
      arm = 1'b1;
      cyc();
      cyc();
      for (int i = 0; i < 3000; i++) strobe(12'h100, a);
      check("no_auto_trigger", triggered, 0);
      check("no_auto_busy", busy, 0);
      arm = 1'b0;
      cyc();
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached, %0d failures so far", n_fail);
      $fatal(1, "watchdog");
   end

endmodule
